// File: rtl/ram_n_pkg.sv
// Shared constants for the ram_n slice: default geometry and clear-sweep state encoding.
// No logic of its own; imported by ram_n and ram_clear_seq.
package ram_n_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear-sweep sequencer: walks ptr over every word address once after reset and flags busy.
// Latency: busy rises the edge after reset, falls the edge that clears word DEPTH-1.
// Backpressure: none; reset restarts the sweep at ptr=0 and holds it there while asserted.
module ram_clear_seq
    import ram_n_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    clr_state_t state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    ptr  <= '0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_n.sv
// Single-port word RAM, combinational read, write-first; optional zero sweep on reset (RAM_N_CLEAR_EN).
// Latency: read 0 cycles, write visible after the edge; sweep takes 2**ADDR_W cycles.
// Backpressure: busy=1 during the sweep; loads are dropped and out reads 0 until it ends.
module ram_n
    import ram_n_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;

`ifdef RAM_N_CLEAR_EN
    logic [ADDR_W-1:0] ptr;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clock (clock),
        .reset (reset),
        .busy  (busy),
        .ptr   (ptr)
    );

    // The sweep owns the write port while busy; reset suppresses every write, sweep included.
    always_comb begin
        we  = ~reset & (busy | load);
        wa  = busy ? ptr : address;
        wd  = busy ? '0 : in;
        out = busy ? '0 : mem[address];
    end
`else
    logic unused_reset;
    assign unused_reset = reset;

    always_comb begin
        we   = load;
        wa   = address;
        wd   = in;
        out  = mem[address];
        busy = 1'b0;
    end
`endif

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_ram_n.sv
// Bench for ram_n: vector table, randomized traffic against an array model, and sweep corner cases.
module tb_ram_n;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic [WIDTH-1:0]  din;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic [WIDTH-1:0]  dout;
    logic              busy;

    int total;
    int bad;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               known   [DEPTH];

    typedef struct {
        bit          ld;
        int unsigned adr;
        logic [15:0] dat;
        bit          chk_pre;
        logic [15:0] pre;
        logic [15:0] post;
    } vec_t;

    vec_t vecs [8];

    ram_n #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .in      (din),
        .address (address),
        .load    (load),
        .out     (dout),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_write(input int a, input logic [15:0] d);
        ref_mem[a] = d;
        known[a]   = 1'b1;
    endtask

    // After a completed sweep the whole array is known to be zero.
    task automatic model_clear;
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = '0;
            known[a]   = 1'b1;
        end
    endtask

    task automatic read_check(input string name, input int a);
        load    = 1'b0;
        address = ADDR_W'(a);
        #1;
        if (known[a]) check(name, dout, ref_mem[a]);
    endtask

    // Counts cycles for which busy stays high, up to limit; optionally tries a write mid-sweep.
    task automatic count_busy(input bit inject, input int limit, output int n);
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            if (inject && n == 10) begin
                load    = 1'b1;
                din     = 16'd7;
                address = 12'd5;
            end else begin
                load    = 1'b0;
                address = ADDR_W'(n * 7);
            end
            #1;
            if (n % 512 == 10) check("out_zero_while_busy", dout, 0);
            tick;
            n++;
        end
        load = 1'b0;
    endtask

    initial begin
        int  n;
        bit  clr;
        int  a;
        bit  ld;
        logic [15:0] d;

        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        din     = '0;
        address = '0;
        load    = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
`ifdef RAM_N_CLEAR_EN
        clr = 1'b1;
`else
        clr = 1'b0;
`endif

        vecs[0] = '{1'b1, 7,    16'd42,     1'b0, 16'd0,      16'd42};
        vecs[1] = '{1'b1, 7,    16'd43,     1'b1, 16'd42,     16'd43};
        vecs[2] = '{1'b0, 7,    16'd99,     1'b1, 16'd43,     16'd43};
        vecs[3] = '{1'b1, 0,    16'h0001,   1'b0, 16'd0,      16'h0001};
        vecs[4] = '{1'b1, 4095, 16'hffff,   1'b0, 16'd0,      16'hffff};
        vecs[5] = '{1'b0, 0,    16'd5,      1'b1, 16'h0001,   16'h0001};
        vecs[6] = '{1'b1, 4095, 16'h1234,   1'b1, 16'hffff,   16'h1234};
        vecs[7] = '{1'b0, 4095, 16'h0000,   1'b1, 16'h1234,   16'h1234};

        repeat (2) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("busy_after_reset", busy, clr);

        if (clr) begin
            check("out_zero_after_reset", dout, 0);
            count_busy(1'b1, 6000, n);
            check("sweep_len_first", n, DEPTH);
            check("busy_clear_after_sweep", busy, 0);
            model_clear();
            read_check("sweep_zero_0", 0);
            read_check("sweep_zero_1024", 1024);
            read_check("sweep_zero_4095", 4095);
            read_check("dropped_load_addr5", 5);

            load = 1'b1; din = 16'd15; address = 12'd1024;
            tick;
            load = 1'b0;
            model_write(1024, 16'd15);
            read_check("single_write_1024", 1024);
            read_check("single_zero_0", 0);
            for (int p = 1; p <= 2048; p = p * 2)
                if (p != 1024) read_check("single_zero_pow2", p);
            read_check("single_zero_4095", 4095);
        end

        for (int i = 0; i < 8; i++) begin
            load    = vecs[i].ld;
            address = ADDR_W'(vecs[i].adr);
            din     = vecs[i].dat;
            #1;
            if (vecs[i].chk_pre) check("vec_pre", dout, vecs[i].pre);
            tick;
            if (vecs[i].ld) model_write(int'(vecs[i].adr), vecs[i].dat);
            check("vec_post", dout, vecs[i].post);
        end
        load = 1'b0;

        for (int i = 0; i < 400; i++) begin
            a  = ($urandom % 4 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 31));
            ld = 1'($urandom);
            d  = 16'($urandom);
            load = ld; address = ADDR_W'(a); din = d;
            #1;
            if (known[a]) check("rand_pre", dout, ref_mem[a]);
            tick;
            if (ld) model_write(a, d);
            if (known[a]) check("rand_post", dout, ref_mem[a]);
        end
        load = 1'b0;

        if (clr) begin
            // Reset held three cycles with a colliding write to address 3.
            load = 1'b1; din = 16'd9; address = 12'd3; reset = 1'b1;
            repeat (3) begin
                tick;
                check("busy_while_reset_held", busy, 1);
                check("out_zero_reset_held", dout, 0);
            end
            reset = 1'b0; load = 1'b0;
            count_busy(1'b0, 6000, n);
            check("sweep_len_after_hold", n, DEPTH);
            model_clear();
            read_check("collision_addr3", 3);
            read_check("hold_cleared_4095", 4095);

            for (int i = 0; i < 8; i++) begin
                load = 1'b1; address = ADDR_W'(i * 500); din = 16'h00a0 + 16'(i);
                tick;
            end
            load  = 1'b0;
            reset = 1'b1;
            tick;
            reset = 1'b0;
            count_busy(1'b0, 100, n);
            check("mid_sweep_still_busy", busy, 1);
            reset = 1'b1;
            tick;
            reset = 1'b0;
            count_busy(1'b0, 6000, n);
            check("sweep_len_restart", n, DEPTH);
            model_clear();
            read_check("restart_zero_500", 500);
            read_check("restart_zero_3500", 3500);
        end else begin
            load = 1'b1; din = 16'd42; address = 12'd7;
            tick;
            load = 1'b0;
            model_write(7, 16'd42);
            reset = 1'b1;
            repeat (2) begin
                tick;
                check("busy_stays_low", busy, 0);
            end
            reset = 1'b0;
            read_check("reset_keeps_addr7", 7);
            read_check("reset_keeps_4095", 4095);

            reset = 1'b1; load = 1'b1; din = 16'd5; address = 12'd9;
            tick;
            reset = 1'b0; load = 1'b0;
            model_write(9, 16'd5);
            read_check("write_during_reset", 9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_n.md
RAM_N -- requirements
Module: ram_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning address width; depth DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in, input, WIDTH bits: write data.
REQ-006 The block SHALL have port address, input, ADDR_W bits: read/write word address.
REQ-007 The block SHALL have port load, input, 1 bit: write enable.
REQ-008 The block SHALL have port out, output, WIDTH bits: read data.
REQ-009 The block SHALL have port busy, output, 1 bit: clear sweep in progress, accesses blocked.

Function
REQ-010 Read SHALL be combinational: out = mem[address] in the same cycle, with no clock latency, when busy=0.
REQ-011 Write: on a rising edge with load=1, busy=0 and reset=0, mem[address] SHALL take in; out SHALL show the new value after that edge.
REQ-012 Write is write-first: with load=1 held, out SHALL show the old word before the edge and the new word after it; there SHALL be no combinational in-to-out path.
REQ-013 Out-of-range addresses SHALL be impossible, since depth equals 2**ADDR_W and every address value is valid.
REQ-014 The state machine SHALL have two states, IDLE and CLEAR; IDLE -> CLEAR on reset=1; CLEAR -> IDLE after word DEPTH-1 is cleared.
REQ-015 In CLEAR, one word per cycle SHALL be written to 0 at clear counter ptr, with ptr counting 0..DEPTH-1; the sweep takes exactly DEPTH cycles after reset deasserts.
REQ-016 busy SHALL be 1 in CLEAR and 0 in IDLE; out SHALL be 0 while busy=1.
REQ-017 load while busy=1 SHALL be dropped silently; there SHALL be no queueing and no error flag.
REQ-018 ptr SHALL not wrap: reaching DEPTH-1 ends the sweep, and ptr SHALL hold 0 in IDLE.
REQ-019 reset asserted mid-sweep SHALL restart the sweep at ptr=0.
REQ-020 reset and load in the same cycle: reset SHALL win and the write is discarded.

Reset
REQ-021 On reset=1 at a rising edge: state SHALL be CLEAR, ptr SHALL be 0, and busy SHALL be 1 from the next cycle.
REQ-022 busy SHALL remain 1 while reset is held; the sweep advances only when reset=0.
REQ-023 After the sweep, every word SHALL read 0.

Configuration
REQ-024 Macro RAM_N_CLEAR_EN defined: the clear sweep, busy behaviour and blocked accesses SHALL be compiled in per REQ-014..REQ-023.
REQ-025 Macro RAM_N_CLEAR_EN undefined: there SHALL be no sweep, counter or state logic; busy SHALL be tied 0; reset SHALL leave contents unchanged; writes are accepted every cycle.

Structure
REQ-026 The shared chapter header SHALL hold the state encodings (IDLE=0, CLEAR=1) and the default WIDTH/ADDR_W constants.
REQ-027 The sweep counter and FSM SHALL be one sub-module, ram_clear_seq (ports clock, reset, busy, ptr), instantiated only under RAM_N_CLEAR_EN.
REQ-028 Storage and the read/write mux SHALL stay in ram_n.

Verification
REQ-029 Sweep length: with RAM_N_CLEAR_EN and defaults, assert reset 1 cycle -> busy=1 for exactly 4096 cycles, then 0; reads of addresses 0, 1024 and 4095 SHALL return 0.
REQ-030 Single write/read: in=15, address=1024, load=1 for one edge -> out=15 at 1024; addresses 0, 1, 2, 4, ... 2048 and 4095 SHALL read 0.
REQ-031 Dropped load while busy: load=1, in=7, address=5 during the sweep -> after the sweep, address 5 SHALL read 0.
REQ-032 Mid-sweep reset: reset at sweep cycle 100 -> busy SHALL stay 1 for 4096 more cycles after release.
REQ-033 Reset/load collision: reset=1, load=1, in=9, address=3 in the same cycle -> the write is discarded and address 3 SHALL read 0 after the sweep.
REQ-034 Macro undefined: write 42 at address 7, then pulse reset -> busy SHALL stay 0 and address 7 SHALL still read 42.
